wb_ram_lat: RTL and testbench

//  Parametrised Wishbone classic slave RAM; successor to the fixed single-cycle test RAM behind memcontrol.

---
 rtl/wb_ram_lat_pkg.sv | 29 ++
 rtl/wb_ram_lat_ram_array.sv | 41 ++++
 rtl/wb_ram_lat.sv | 147 ++++++++++++++
 tb/tb_wb_ram_lat.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_lat_pkg.sv
// Shared definitions for wb_ram_lat: FSM state encoding, counter sizing,
// latency legality check and Wishbone byte-lane helpers.
package wb_ram_lat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Wide enough to hold LATENCY-1 for the largest legal latency.
    localparam int CNT_W       = 4;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    function automatic int lanes_of(input int width);
        return width / 8;
    endfunction

    // Number of byte-offset bits below the word index in a byte address.
    function automatic int lane_addr_bits(input int width);
        return (width > 8) ? $clog2(width / 8) : 0;
    endfunction

    function automatic bit latency_ok(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/wb_ram_lat_ram_array.sv
// wb_ram_lat_ram_array: single-port-per-direction RAM with a registered
// read port and byte-enable write port. Contents are not reset.
module wb_ram_lat_ram_array #(
    parameter int WIDTH   = 128,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter     ROMPATH = ""
) (
    input  logic               clk,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [WIDTH-1:0]   o_rd_data,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [WIDTH/8-1:0] i_wr_be,
    input  logic [WIDTH-1:0]   i_wr_data
);

    if ((WIDTH % 8) != 0 || DEPTH < 1) begin : g_bad_geometry
        $error("wb_ram_lat_ram_array: illegal geometry for image '%s'", ROMPATH);
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Byte-lane write and synchronous read of the addressed word.
    // NOTE: the array deliberately has no reset branch; clearing a memory
    // on reset would turn it into a huge register bank instead of a RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wb_ram_lat.sv
// wb_ram_lat: Wishbone classic slave RAM with programmable wait states,
// error termination for out-of-range words and abort on cyc_i drop.
module wb_ram_lat
    import wb_ram_lat_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 1,
    parameter     ROMPATH = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  adr_i,
    input  logic [WIDTH-1:0]   dat_i,
    output logic [WIDTH-1:0]   dat_o,
    input  logic               we_i,
    input  logic [WIDTH/8-1:0] sel_i,
    input  logic               stb_i,
    input  logic               cyc_i,
    output logic               ack_o,
    output logic               err_o
);

    localparam int LANES  = lanes_of(WIDTH);
    localparam int OFS_W  = lane_addr_bits(WIDTH);
    localparam int IDX_W  = ADDR_W - OFS_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("wb_ram_lat: LATENCY %0d outside legal range", LATENCY);
    end

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [MEM_AW-1:0]  r_idx;
    logic               r_oor;
    logic               r_we;
    logic [LANES-1:0]   r_sel;
    logic [WIDTH-1:0]   r_wdat;

    logic [IDX_W-1:0]   w_req_idx;
    logic               w_req_oor;
    logic               w_accept;
    logic [MEM_AW-1:0]  w_rd_idx;
    logic [WIDTH-1:0]   w_rdata;
    logic               w_wr_en;

    assign w_req_idx = adr_i[ADDR_W-1:OFS_W];
    assign w_req_oor = (32'(w_req_idx) >= 32'(DEPTH));
    assign w_accept  = (r_state == ST_IDLE) && cyc_i && stb_i;

    // While idle the RAM reads the live address so the word is ready for a
    // single-cycle response; afterwards it keeps reading the latched index.
    assign w_rd_idx = (r_state == ST_IDLE) ? w_req_idx[MEM_AW-1:0] : r_idx;

    // State register.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept, count down wait states, abort, respond.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (CNT_LOAD == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latches and wait-state counter; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_oor  <= 1'b0;
            r_we   <= 1'b0;
            r_sel  <= '0;
            r_wdat <= '0;
        end else if (w_accept) begin
            r_cnt  <= CNT_LOAD;
            r_idx  <= w_req_idx[MEM_AW-1:0];
            r_oor  <= w_req_oor;
            r_we   <= we_i;
            r_sel  <= sel_i;
            r_wdat <= dat_i;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Response outputs: one-cycle ack or err, read data only on a read ack.
    always_comb begin
        ack_o   = 1'b0;
        err_o   = 1'b0;
        w_wr_en = 1'b0;
        dat_o   = '0;
        if (r_state == ST_RESP) begin
            if (r_oor) begin
                err_o = 1'b1;
            end else begin
                ack_o   = 1'b1;
                w_wr_en = r_we;
                if (!r_we) begin
                    dat_o = w_rdata;
                end
            end
        end
    end

    wb_ram_lat_ram_array #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AW      (MEM_AW),
        .ROMPATH (ROMPATH)
    ) u_ram (
        .clk       (clk),
        .i_rd_addr (w_rd_idx),
        .o_rd_data (w_rdata),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_idx),
        .i_wr_be   (r_sel),
        .i_wr_data (r_wdat)
    );

endmodule

// File: tb/tb_wb_ram_lat.sv
// Testbench for wb_ram_lat: three instances (LATENCY 1, 4, 6) checked
// against a word-array model of the RAM contents.
module tb_wb_ram_lat;

    localparam int NI    = 3;
    localparam int W     = 128;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam logic [127:0] DEAD = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] PATT = 128'hA5A5_5A5A_1234_5678_9ABC_DEF0_C3C3_3C3C;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 6;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr   [NI];
    logic [W-1:0]  dat_i [NI];
    logic [W-1:0]  dat_o [NI];
    logic          we    [NI];
    logic [15:0]   sel   [NI];
    logic          stb   [NI];
    logic          cyc   [NI];
    logic          ack   [NI];
    logic          err   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wb_ram_lat #(
            .WIDTH   (W),
            .ADDR_W  (AW),
            .DEPTH   (DEPTH),
            .LATENCY (lat_of(g)),
            .ROMPATH ("")
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .adr_i (adr[g]),
            .dat_i (dat_i[g]),
            .dat_o (dat_o[g]),
            .we_i  (we[g]),
            .sel_i (sel[g]),
            .stb_i (stb[g]),
            .cyc_i (cyc[g]),
            .ack_o (ack[g]),
            .err_o (err[g])
        );
    end

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference contents, one word array per instance.
    logic [127:0] mem [NI][DEPTH];

    typedef struct {
        int           k;
        logic [15:0]  adr;
        logic         we;
        logic [15:0]  sel;
        logic [127:0] dat;
        logic         exp_err;
        logic [127:0] exp_dat;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: word index is the byte address divided by 16; out of range
    // means error and no effect; writes merge selected bytes.
    function automatic void model_op(input int k, input logic [15:0] a, input logic w,
                                     input logic [15:0] s, input logic [127:0] d,
                                     output logic e, output logic [127:0] q);
        int idx;
        idx = int'(a) / 16;
        e = (idx >= DEPTH);
        q = '0;
        if (!e) begin
            if (w) begin
                for (int b = 0; b < 16; b++) begin
                    if (s[b]) mem[k][idx][b*8 +: 8] = d[b*8 +: 8];
                end
            end else begin
                q = mem[k][idx];
            end
        end
    endfunction

    // One complete transfer; request fields are scrambled while waiting.
    task automatic xfer(input int k, input logic [15:0] a, input logic w, input logic [15:0] s,
                        input logic [127:0] d, output logic got_err, output logic [127:0] got_dat,
                        output int lat);
        adr[k] = a; we[k] = w; sel[k] = s; dat_i[k] = d;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        step();
        lat = 0; got_err = 1'b0; got_dat = '0;
        for (int c = 1; c <= 20; c++) begin
            if (ack[k] || err[k]) begin
                lat = c;
                got_err = err[k];
                got_dat = dat_o[k];
                check($sformatf("k%0d onehot", k), 128'(ack[k] ^ err[k]), 128'(1));
                break;
            end
            adr[k]   = 16'($urandom);
            dat_i[k] = {4{$urandom}};
            sel[k]   = 16'($urandom);
            we[k]    = 1'($urandom);
            step();
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        step();
        check($sformatf("k%0d pulse", k), {ack[k], err[k]}, 128'(0));
    endtask

    task automatic run_op(input string tag, input int k, input logic [15:0] a, input logic w,
                          input logic [15:0] s, input logic [127:0] d,
                          input logic exp_err, input logic [127:0] exp_dat);
        logic         ge;
        logic [127:0] gd;
        int           lat;
        xfer(k, a, w, s, d, ge, gd, lat);
        check({tag, " lat"}, 128'(lat), 128'(lat_of(k)));
        check({tag, " err"}, 128'(ge), 128'(exp_err));
        if (!w || exp_err) check({tag, " dat"}, gd, exp_dat);
    endtask

    task automatic wait_resp(input int k, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (ack[k] || err[k]) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         e;
        logic [127:0] q;
        bit           seen;
        int           k;
        logic [15:0]  a;
        logic         w;
        logic [15:0]  s;
        logic [127:0] d;

        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            adr[i] = '0; dat_i[i] = '0; we[i] = 1'b0; sel[i] = '0;
            stb[i] = 1'b0; cyc[i] = 1'b0;
        end
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset k%0d", i), {ack[i], err[i], dat_o[i]}, 128'(0));
        end
        rst = 1'b1;
        step();

        // Preload every word with zero.
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                model_op(i, 16'(j * 16), 1'b1, 16'hFFFF, '0, e, q);
                run_op($sformatf("pre k%0d w%0d", i, j), i, 16'(j * 16), 1'b1, 16'hFFFF, '0, e, q);
            end
        end

        // Directed vectors with hand-derived expectations.
        tbl[0]  = '{0, 16'h0010, 1'b1, 16'hFFFF, DEAD, 1'b0, '0};
        tbl[1]  = '{0, 16'h0010, 1'b0, 16'hFFFF, '0,   1'b0, DEAD};
        tbl[2]  = '{1, 16'h0020, 1'b0, 16'hFFFF, '0,   1'b0, '0};
        tbl[3]  = '{0, 16'h0030, 1'b1, 16'h000F, ONES, 1'b0, '0};
        tbl[4]  = '{0, 16'h0030, 1'b0, 16'h0000, '0,   1'b0, 128'hFFFF_FFFF};
        tbl[5]  = '{0, 16'h0100, 1'b1, 16'hFFFF, ONES, 1'b1, '0};
        tbl[6]  = '{0, 16'h0100, 1'b0, 16'hFFFF, '0,   1'b1, '0};
        tbl[7]  = '{0, 16'h0000, 1'b0, 16'hFFFF, '0,   1'b0, '0};
        tbl[8]  = '{2, 16'h0040, 1'b1, 16'h0000, ONES, 1'b0, '0};
        tbl[9]  = '{2, 16'h0045, 1'b0, 16'hFFFF, '0,   1'b0, '0};
        tbl[10] = '{1, 16'hFFF0, 1'b0, 16'hFFFF, '0,   1'b1, '0};
        tbl[11] = '{2, 16'h00F8, 1'b1, 16'hFFFF, PATT, 1'b0, '0};
        tbl[12] = '{2, 16'h00F0, 1'b0, 16'h0000, '0,   1'b0, PATT};
        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].k, tbl[i].adr, tbl[i].we, tbl[i].sel,
                   tbl[i].dat, tbl[i].exp_err, tbl[i].exp_dat);
            model_op(tbl[i].k, tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, e, q);
        end

        // Strobe held high at LATENCY=1: ack every other cycle.
        adr[0] = 16'h0010; we[0] = 1'b0; sel[0] = 16'hFFFF; cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("b2b ack%0d", c), 128'(ack[0]), 128'((c % 2) == 0));
            if ((c % 2) == 0) check($sformatf("b2b dat%0d", c), dat_o[0], DEAD);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        step();

        // Abort: drop cyc during wait states of a LATENCY=6 write.
        adr[2] = 16'h0050; we[2] = 1'b1; sel[2] = 16'hFFFF; dat_i[2] = ONES;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        step();
        step();
        check("abort wait", {ack[2], err[2]}, 128'(0));
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("abort quiet%0d", c), {ack[2], err[2]}, 128'(0));
        end
        model_op(2, 16'h0050, 1'b0, 16'hFFFF, '0, e, q);
        run_op("abort rb", 2, 16'h0050, 1'b0, 16'hFFFF, '0, e, q);

        // Reset during wait states of a write.
        model_op(2, 16'h0060, 1'b1, 16'hFFFF, PATT, e, q);
        run_op("rst pre", 2, 16'h0060, 1'b1, 16'hFFFF, PATT, e, q);
        adr[2] = 16'h0060; we[2] = 1'b1; sel[2] = 16'hFFFF; dat_i[2] = ONES;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst wait out", {ack[2], err[2], dat_o[2]}, 128'(0));
        cyc[2] = 1'b0; stb[2] = 1'b0;
        #2 rst = 1'b1;
        step();
        run_op("rst wait rb", 2, 16'h0060, 1'b0, 16'hFFFF, '0, 1'b0, PATT);

        // Reset during the response cycle of a read.
        adr[2] = 16'h0060; we[2] = 1'b0; sel[2] = 16'hFFFF; cyc[2] = 1'b1; stb[2] = 1'b1;
        wait_resp(2, seen);
        check("rst resp seen", 128'(seen), 128'(1));
        check("rst resp dat", dat_o[2], PATT);
        rst = 1'b0;
        #1;
        check("rst resp out", {ack[2], err[2], dat_o[2]}, 128'(0));
        cyc[2] = 1'b0; stb[2] = 1'b0;
        #2 rst = 1'b1;
        step();

        // Reset during the response cycle of a write: nothing committed.
        adr[2] = 16'h0060; we[2] = 1'b1; sel[2] = 16'hFFFF; dat_i[2] = ONES;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        wait_resp(2, seen);
        check("rst wresp seen", 128'(seen), 128'(1));
        rst = 1'b0;
        #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        #2 rst = 1'b1;
        step();
        run_op("rst wresp rb", 2, 16'h0060, 1'b0, 16'hFFFF, '0, 1'b0, PATT);

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = 16'($urandom);
            else a = 16'(($urandom_range(0, 19) << 4) | $urandom_range(0, 15));
            w = 1'($urandom);
            s = 16'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            model_op(k, a, w, s, d, e, q);
            run_op($sformatf("rand%0d", n), k, a, w, s, d, e, q);
        end

        // Final sweep: every in-range word of every instance.
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                model_op(i, 16'(j * 16), 1'b0, 16'h0, '0, e, q);
                run_op($sformatf("sweep k%0d w%0d", i, j), i, 16'(j * 16), 1'b0, 16'h0, '0, e, q);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
